// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM.
// States, instruction classes, encodings and the ALU class helper.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_IF, S_ID, S_EXE, S_WB, S_MADDR, S_MEM,
        S_LWB, S_BR, S_J, S_JR, S_LINK, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_SHIFT, C_JR, C_JALR, C_IMM, C_LW,
        C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_MDR    = 2'b00;
    localparam logic [1:0] M2R_ALUOUT = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] ASRC_PC    = 2'b00;
    localparam logic [1:0] ASRC_RS    = 2'b01;
    localparam logic [1:0] ASRC_SHAMT = 2'b10;

    localparam logic [1:0] BSRC_RT     = 2'b00;
    localparam logic [1:0] BSRC_FOUR   = 2'b01;
    localparam logic [1:0] BSRC_IMM    = 2'b10;
    localparam logic [1:0] BSRC_IMM_SH = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_BUS     = 2'b10;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    function automatic logic [2:0] alu_class(iclass_t c, logic [5:0] op);
        logic [2:0] r;
        r = ALU_ADD;
        if (c == C_RALU || c == C_SHIFT || c == C_JR || c == C_JALR)
            r = ALU_FUNCT;
        else if (c == C_BEQ)
            r = ALU_SUB;
        else if (op == OP_ANDI)
            r = ALU_AND;
        else if (op == OP_SLTI || op == OP_SLTIU)
            r = ALU_SLT;
        return r;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class plus legal flag.
// Anything not in the supported subset decodes to C_ILL.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic       legal
);

    always_comb begin
        iclass = C_ILL;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_JR:   iclass = C_JR;
                    FN_JALR: iclass = C_JALR;
                    FN_SLL, FN_SRL, FN_SRA:
                        iclass = C_SHIFT;
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU:
                        iclass = C_RALU;
                    default: iclass = C_ILL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_SLTI, OP_SLTIU, OP_LUI:
                iclass = C_IMM;
            OP_LW:   iclass = C_LW;
            OP_SW:   iclass = C_SW;
            OP_BEQ:  iclass = C_BEQ;
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            default: iclass = C_ILL;
        endcase
    end

    assign legal = (iclass != C_ILL);

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with req/ready memory handshake and trap halt.
// Define MC_CTRL_PERF_EN to add instr_retired/stall_cycles counters.
module mc_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               ext_op,
    output logic               lui_op,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               fault,
    output logic [1:0]         fault_code
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]        instr_retired,
    output logic [31:0]        stall_cycles
`endif
);

    state_t           state;
    state_t           state_nxt;
    iclass_t          iclass;
    logic             legal;
    logic [TMO_W-1:0] wait_cnt;
    logic [1:0]       code_q;
    logic [1:0]       trap_code;
    logic [2:0]       cls;
    logic [2:0]       alu_cls;
    logic             alu_live;
    logic             timeout;
    logic             is_r;

    mc_ctrl_decode u_dec (
        .opcode (opcode),
        .funct  (funct),
        .iclass (iclass),
        .legal  (legal)
    );

    assign cls     = alu_class(iclass, opcode);
    assign timeout = (wait_cnt == TMO_W'(MEM_TIMEOUT)) && !mem_ready;
    assign is_r    = (iclass == C_RALU) || (iclass == C_SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            code_q   <= FAULT_NONE;
        end else begin
            state <= state_nxt;
            if (mem_ready || (state_nxt != state &&
                (state_nxt == S_IF || state_nxt == S_MEM)))
                wait_cnt <= '0;
            else if (mem_req)
                wait_cnt <= wait_cnt + 1'b1;
            if (trap_code != FAULT_NONE)
                code_q <= trap_code;
        end
    end

    always_comb begin
        state_nxt     = state;
        trap_code     = FAULT_NONE;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        reg_write     = 1'b0;
        reg_dst       = REGDST_RT;
        mem_to_reg    = M2R_MDR;
        ext_op        = 1'b0;
        lui_op        = 1'b0;
        alu_src_a     = ASRC_PC;
        alu_src_b     = BSRC_RT;
        alu_cls       = ALU_ADD;
        alu_live      = 1'b1;
        unique case (state)
            S_IDLE: begin
                alu_live  = 1'b0;
                state_nxt = S_IF;
            end
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = BSRC_FOUR;
                    state_nxt = S_ID;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    trap_code = FAULT_BUS;
                end
            end
            S_ID: begin
                alu_src_b = BSRC_IMM_SH;
                if (!legal) begin
                    state_nxt = S_TRAP;
                    trap_code = FAULT_ILLEGAL;
                end else begin
                    unique case (iclass)
                        C_RALU, C_SHIFT, C_IMM: state_nxt = S_EXE;
                        C_JR:                   state_nxt = S_JR;
                        C_JALR, C_JAL:          state_nxt = S_LINK;
                        C_LW, C_SW:             state_nxt = S_MADDR;
                        C_BEQ:                  state_nxt = S_BR;
                        C_J:                    state_nxt = S_J;
                        default:                state_nxt = S_TRAP;
                    endcase
                end
            end
            S_EXE: begin
                alu_cls = cls;
                if (iclass == C_SHIFT) begin
                    alu_src_a = ASRC_SHAMT;
                end else if (iclass == C_RALU) begin
                    alu_src_a = ASRC_RS;
                end else begin
                    alu_src_a = ASRC_RS;
                    alu_src_b = BSRC_IMM;
                    ext_op    = 1'b1;
                    lui_op    = (opcode == OP_LUI);
                end
                state_nxt = S_WB;
            end
            S_WB: begin
                alu_cls    = cls;
                reg_write  = 1'b1;
                mem_to_reg = M2R_ALUOUT;
                reg_dst    = is_r ? REGDST_RD : REGDST_RT;
                state_nxt  = S_IF;
            end
            S_MADDR: begin
                alu_src_a = ASRC_RS;
                alu_src_b = BSRC_IMM;
                ext_op    = 1'b1;
                state_nxt = S_MEM;
            end
            S_MEM: begin
                alu_cls = cls;
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OP_SW);
                if (mem_ready) begin
                    state_nxt = (iclass == C_LW) ? S_LWB : S_IF;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    trap_code = FAULT_BUS;
                end
            end
            S_LWB: begin
                alu_cls   = cls;
                reg_write = 1'b1;
                state_nxt = S_IF;
            end
            S_BR: begin
                alu_cls       = cls;
                alu_src_a     = ASRC_RS;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_nxt     = S_IF;
            end
            S_J: begin
                alu_cls   = cls;
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_nxt = S_IF;
            end
            S_JR: begin
                alu_cls   = cls;
                pc_write  = 1'b1;
                pc_source = PCSRC_RS;
                state_nxt = S_IF;
            end
            // Register file samples the old PC while the PC itself updates.
            S_LINK: begin
                alu_cls    = cls;
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC;
                pc_write   = 1'b1;
                if (iclass == C_JAL) begin
                    reg_dst   = REGDST_RA;
                    pc_source = PCSRC_JUMP;
                end else begin
                    reg_dst   = REGDST_RD;
                    pc_source = PCSRC_RS;
                end
                state_nxt = S_IF;
            end
            S_TRAP: begin
                alu_live = 1'b0;
            end
            default: begin
                alu_live  = 1'b0;
                state_nxt = S_TRAP;
            end
        endcase
    end

    always_comb begin
        alu_op = '0;
        if (alu_live) begin
            alu_op[2:0]         = alu_cls;
            alu_op[ALUOP_W-1]   = opcode[0];
        end
    end

    assign fault      = (state == S_TRAP);
    assign fault_code = code_q;

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_retired <= '0;
            stall_cycles  <= '0;
        end else begin
            if (state_nxt == S_IF && state != S_IF && state != S_IDLE)
                instr_retired <= instr_retired + 32'd1;
            if (mem_req && !mem_ready)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Self-checking bench for mc_ctrl_hs: per-instruction expected control
// sequences built from the instruction semantics, directed and random.
module tb_mc_ctrl_hs;

    localparam int TMO = 15;

    localparam int K_R    = 0;
    localparam int K_SH   = 1;
    localparam int K_IMM  = 2;
    localparam int K_LW   = 3;
    localparam int K_SW   = 4;
    localparam int K_BEQ  = 5;
    localparam int K_J    = 6;
    localparam int K_JAL  = 7;
    localparam int K_JR   = 8;
    localparam int K_JALR = 9;
    localparam int K_ILL  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_a, alu_src_b;
    logic       reg_write, ext_op, lui_op, fault;
    logic [3:0] alu_op;
    logic [1:0] fault_code;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       ext_op;
        logic       lui_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       fault;
        logic [1:0] fault_code;
    } ctl_t;

    ctl_t obs;

    mc_ctrl_hs dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .ext_op        (ext_op),
        .lui_op        (lui_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                  pc_source, reg_write, reg_dst, mem_to_reg, ext_op, lui_op,
                  alu_src_a, alu_src_b, alu_op, fault, fault_code};

    always #5 clk = ~clk;

    logic [5:0] ops [15] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04,
                             6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f,
                             6'h23, 6'h2b, 6'h3f};
    logic [5:0] fns [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                             6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02,
                             6'h03, 6'h08, 6'h09};

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h08) return K_JR;
            if (fn == 6'h09) return K_JALR;
            if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) return K_SH;
            if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2a || fn == 6'h2b)
                return K_R;
            return K_ILL;
        end
        case (op)
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: return K_IMM;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] cls_of(input int k, input logic [5:0] op);
        if (k == K_R || k == K_SH || k == K_JR || k == K_JALR) return 3'b010;
        if (k == K_BEQ) return 3'b001;
        if (op == 6'h0c) return 3'b100;
        if (op == 6'h0a || op == 6'h0b) return 3'b101;
        return 3'b000;
    endfunction

    function automatic ctl_t base(input logic [5:0] op);
        ctl_t e;
        e = '0;
        e.alu_op = {op[0], 3'b000};
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input ctl_t exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy, input ctl_t e, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        #1;
        check(e, tag);
    endtask

    task automatic async_reset(input string tag);
        ctl_t z;
        z = '0;
        #2 reset = 1'b1;
        #1 check(z, tag);
        @(negedge clk);
        reset = 1'b0;
        #1 check(z, "idle_after_rst");
    endtask

    task automatic trap(input logic [1:0] code);
        ctl_t e;
        e = '0;
        e.fault = 1'b1;
        e.fault_code = code;
        repeat (3) step(rbit(), e, "trap_hold");
        async_reset("trap_async_rst");
    endtask

    // Waits count from zero each access; timeout fires on the cycle that has
    // already waited TMO cycles and still sees no ready.
    task automatic access(input int stalls, input ctl_t w, input string tag,
                          output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            step(1'b0, w, tag);
            if (i == TMO) begin
                trapped = 1'b1;
                return;
            end
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input int fst, input int mst);
        int   k;
        bit   t;
        ctl_t e;
        logic [2:0] c;
        k = kind_of(op, fn);
        c = cls_of(k, op);
        @(posedge clk);
        #1;
        opcode = op;
        funct = fn;
        e = base(op);
        e.mem_req = 1'b1;
        access(fst, e, "if_wait", t);
        if (t) begin
            trap(2'b10);
            return;
        end
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        e.alu_src_b = 2'b01;
        step(1'b1, e, "if_done");
        e = base(op);
        e.alu_src_b = 2'b11;
        step(rbit(), e, "id");
        if (k == K_ILL) begin
            trap(2'b01);
            return;
        end
        e = base(op);
        e.alu_op[2:0] = c;
        case (k)
            K_R, K_SH, K_IMM: begin
                e.alu_src_a = (k == K_SH) ? 2'b10 : 2'b01;
                if (k == K_IMM) begin
                    e.alu_src_b = 2'b10;
                    e.ext_op = 1'b1;
                    e.lui_op = (op == 6'h0f);
                end
                step(rbit(), e, "exe");
                e = base(op);
                e.alu_op[2:0] = c;
                e.reg_write = 1'b1;
                e.mem_to_reg = 2'b01;
                e.reg_dst = (k == K_IMM) ? 2'b00 : 2'b01;
                step(rbit(), e, "wb");
            end
            K_LW, K_SW: begin
                e.alu_src_a = 2'b01;
                e.alu_src_b = 2'b10;
                e.ext_op = 1'b1;
                step(rbit(), e, "maddr");
                e = base(op);
                e.mem_req = 1'b1;
                e.iord = 1'b1;
                e.mem_we = (k == K_SW);
                access(mst, e, "mem_wait", t);
                if (t) begin
                    trap(2'b10);
                    return;
                end
                step(1'b1, e, "mem_done");
                if (k == K_LW) begin
                    e = base(op);
                    e.reg_write = 1'b1;
                    step(rbit(), e, "lwb");
                end
            end
            K_BEQ: begin
                e.alu_src_a = 2'b01;
                e.pc_write_cond = 1'b1;
                e.pc_source = 2'b01;
                step(rbit(), e, "br");
            end
            K_J, K_JR: begin
                e.pc_write = 1'b1;
                e.pc_source = (k == K_J) ? 2'b10 : 2'b11;
                step(rbit(), e, "jump");
            end
            default: begin
                e.reg_write = 1'b1;
                e.mem_to_reg = 2'b10;
                e.pc_write = 1'b1;
                e.reg_dst = (k == K_JAL) ? 2'b10 : 2'b01;
                e.pc_source = (k == K_JAL) ? 2'b10 : 2'b11;
                step(rbit(), e, "link");
            end
        endcase
    endtask

    initial begin
        ctl_t z;
        ctl_t w;
        logic [5:0] op;
        logic [5:0] fn;
        int fst;
        int mst;
        z = '0;
        repeat (2) @(negedge clk);
        #1 check(z, "reset_state");
        reset = 1'b0;
        #1 check(z, "idle");

        run(6'h00, 6'h20, 0, 0);
        run(6'h23, 6'h00, 0, 3);
        run(6'h04, 6'h00, 2, 0);
        run(6'h03, 6'h00, 0, 0);
        run(6'h00, 6'h08, 1, 0);
        run(6'h00, 6'h09, 0, 0);
        run(6'h0f, 6'h00, 0, 0);
        run(6'h0c, 6'h00, 0, 0);
        run(6'h00, 6'h02, 0, 0);
        run(6'h2b, 6'h00, 15, 15);
        run(6'h2b, 6'h00, 0, 100);
        run(6'h3f, 6'h00, 0, 0);
        run(6'h00, 6'h01, 0, 0);
        run(6'h08, 6'h00, 16, 0);
        run(6'h0a, 6'h00, 14, 0);

        @(posedge clk);
        #1;
        opcode = 6'h23;
        w = base(opcode);
        w.mem_req = 1'b1;
        step(1'b0, w, "if_wait");
        step(1'b0, w, "if_wait");
        async_reset("rst_mid_fetch");

        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 14)];
            fn = (op == 6'h00 && $urandom_range(0, 5) != 0)
                 ? fns[$urandom_range(0, 14)]
                 : 6'($urandom_range(0, 63));
            fst = ($urandom_range(0, 11) == 0) ? 16 : $urandom_range(0, 15);
            mst = ($urandom_range(0, 7) == 0) ? 17 : $urandom_range(0, 15);
            run(op, fn, fst, mst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
